// File: rtl/perceptron_uart_ctrl.sv
// Command sequencer between the UART byte stream and the perceptron core:
// loads weights/inputs, launches an evaluation and returns result/ACK/error bytes.
//
// state    | meaning
// IDLE     | waiting for a command byte
// LOAD_W   | receiving N_INPUTS weights then the bias
// LOAD_X   | receiving N_INPUTS inputs
// ACK      | sending 0x06 once the transmitter is free
// START    | one-cycle evaluate request to the core
// WAIT_NN  | waiting for the core's done strobe
// SEND     | sending last_result once the transmitter is free
// ERR      | sending 0x3F once the transmitter is free
module perceptron_uart_ctrl #(
  parameter int fp_integer_width = 4,
  parameter int fp_fract_width   = 4,
  parameter int N_INPUTS         = 2,
  parameter int TIMEOUT_CYCLES   = 120000
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [7:0]                               rx_data,
  input  logic                                     rx_valid,
  output logic [7:0]                               tx_data,
  output logic                                     tx_start,
  input  logic                                     tx_busy,
  output logic                                     wr_en,
  output logic                                     wr_sel,
  output logic [3:0]                               wr_addr,
  output logic [fp_integer_width+fp_fract_width-1:0] wr_data,
  output logic                                     nn_start,
  input  logic                                     nn_done,
  input  logic [fp_integer_width+fp_fract_width-1:0] nn_result,
  output logic                                     busy
);

  localparam int WORD = fp_integer_width + fp_fract_width;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_W     = 4'(N_INPUTS);
  localparam logic [3:0]    LAST_X     = 4'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_X, ACK, START, WAIT_NN, SEND, ERR
  } state_t;

  state_t          state, state_d;
  logic [3:0]      idx, idx_d;
  logic [TW-1:0]   timer, timer_d;
  logic [WORD-1:0] last_result, last_result_d;
  logic            wr_en_d, wr_sel_d, nn_start_d, tx_start_d;
  logic [3:0]      wr_addr_d;
  logic [WORD-1:0] wr_data_d;
  logic [7:0]      tx_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      last_result <= '0;
      wr_en       <= 1'b0;
      wr_sel      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      nn_start    <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      timer       <= timer_d;
      last_result <= last_result_d;
      wr_en       <= wr_en_d;
      wr_sel      <= wr_sel_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      nn_start    <= nn_start_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
    end
  end

  // Pulses are registered, so each lands one cycle after the decision; this keeps
  // the last write strobe clear of the following nn_start or ACK tx_start.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    timer_d       = timer;
    last_result_d = last_result;
    wr_en_d       = 1'b0;
    wr_sel_d      = wr_sel;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    nn_start_d    = 1'b0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data;

    case (state)
      IDLE: begin
        timer_d = '0;
        if (rx_valid) begin
          idx_d = '0;
          case (rx_data)
            8'h57:   state_d = LOAD_W;
            8'h58:   state_d = LOAD_X;
            8'h52:   state_d = SEND;
            default: state_d = ERR;
          endcase
        end
      end
      LOAD_W, LOAD_X: begin
        if (rx_valid) begin
          timer_d   = '0;
          wr_en_d   = 1'b1;
          wr_sel_d  = (state == LOAD_X);
          wr_addr_d = idx;
          wr_data_d = rx_data;
          idx_d     = idx + 4'd1;
          if (state == LOAD_W && idx == LAST_W) state_d = ACK;
          if (state == LOAD_X && idx == LAST_X) state_d = START;
        end else if (timer == TIMER_LAST) begin
          timer_d = '0;
          state_d = ERR;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      ACK: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'h06;
          state_d    = IDLE;
        end
      end
      START: begin
        nn_start_d = 1'b1;
        state_d    = WAIT_NN;
      end
      WAIT_NN: begin
        if (nn_done) begin
          last_result_d = nn_result;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = last_result;
          state_d    = IDLE;
        end
      end
      ERR: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'h3F;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_perceptron_uart_ctrl.sv
// Directed bench for perceptron_uart_ctrl: frame parsing, evaluation, errors,
// timeout, transmitter back-pressure and mid-frame reset.
module tb_perceptron_uart_ctrl;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       wr_en, wr_sel;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       nn_start;
  logic       nn_done = 1'b0;
  logic [7:0] nn_result = '0;
  logic       busy;

  int tests_run = 0;
  int failed = 0;

  int wr_cnt = 0, tx_cnt = 0, nn_cnt = 0, viol = 0;
  logic       wr_sel_log  [32];
  logic [3:0] wr_addr_log [32];
  logic [7:0] wr_data_log [32];
  logic [7:0] tx_log      [32];

  perceptron_uart_ctrl #(
    .fp_integer_width(4), .fp_fract_width(4), .N_INPUTS(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .nn_start(nn_start), .nn_done(nn_done), .nn_result(nn_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_sel_log[wr_cnt % 32]  = wr_sel;
      wr_addr_log[wr_cnt % 32] = wr_addr;
      wr_data_log[wr_cnt % 32] = wr_data;
      wr_cnt++;
    end
    if (tx_start) begin
      tx_log[tx_cnt % 32] = tx_data;
      tx_cnt++;
    end
    if (nn_start) nn_cnt++;
    if (int'(wr_en) + int'(nn_start) + int'(tx_start) > 1) viol++;
    if (tx_start && tx_busy) viol++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int base, input int limit, output bit got);
    int n = 0;
    while (tx_cnt == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    got = (tx_cnt != base);
  endtask

  task automatic wait_nn(input int base, input int limit, output bit got);
    int n = 0;
    while (nn_cnt == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    got = (nn_cnt != base);
  endtask

  task automatic pulse_done(input logic [7:0] r);
    @(negedge clk);
    nn_result = r;
    nn_done   = 1'b1;
    @(negedge clk);
    nn_done   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    tests_run++;
    if ({wr_en, nn_start, tx_start, busy} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_strobes: got %b expected 0000", {wr_en, nn_start, tx_start, busy});
    end
    tests_run++;
    if ({tx_data, wr_data, wr_addr, wr_sel} !== 21'd0) begin
      failed++;
      $display("FAIL reset_data: got tx=%h wd=%h wa=%h ws=%b expected all 0",
               tx_data, wr_data, wr_addr, wr_sel);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_weights;
    logic [7:0] exp_d [3] = '{8'h10, 8'h20, 8'h08};
    int wb = wr_cnt, tb = tx_cnt, nb = nn_cnt;
    bit got;
    send_byte(8'h57);
    idle(2);
    send_byte(8'h10);
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd0) begin
      failed++;
      $display("FAIL w_latency: got wr_en=%b addr=%0d expected 1 / 0", wr_en, wr_addr);
    end
    idle(2);
    send_byte(8'h20);
    idle(1);
    send_byte(8'h08);
    wait_tx(tb, 50, got);
    tests_run++;
    if (!got || tx_log[tb % 32] !== 8'h06) begin
      failed++;
      $display("FAIL w_ack: got %h (seen=%0d) expected 06", tx_log[tb % 32], got);
    end
    tests_run++;
    if (wr_cnt - wb !== 3) begin
      failed++;
      $display("FAIL w_count: got %0d expected 3", wr_cnt - wb);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (wr_sel_log[(wb + i) % 32] !== 1'b0 || wr_addr_log[(wb + i) % 32] !== 4'(i) ||
          wr_data_log[(wb + i) % 32] !== exp_d[i]) begin
        failed++;
        $display("FAIL w_write%0d: got sel=%b addr=%0d data=%h expected 0/%0d/%h", i,
                 wr_sel_log[(wb + i) % 32], wr_addr_log[(wb + i) % 32],
                 wr_data_log[(wb + i) % 32], i, exp_d[i]);
      end
    end
    tests_run++;
    if (nn_cnt != nb) begin
      failed++;
      $display("FAIL w_no_start: got %0d nn_start expected 0", nn_cnt - nb);
    end
  endtask

  task automatic test_eval;
    logic [7:0] exp_d [2] = '{8'h10, 8'hF0};
    int wb = wr_cnt, tb = tx_cnt, nb = nn_cnt;
    bit got;
    send_byte(8'h58);
    send_byte(8'h10);
    idle(1);
    send_byte(8'hF0);
    wait_nn(nb, 20, got);
    tests_run++;
    if (!got) begin
      failed++;
      $display("FAIL x_start: got no nn_start expected 1");
    end
    idle(4);
    pulse_done(8'h1C);
    wait_tx(tb, 50, got);
    tests_run++;
    if (!got || tx_log[tb % 32] !== 8'h1C) begin
      failed++;
      $display("FAIL x_result: got %h (seen=%0d) expected 1c", tx_log[tb % 32], got);
    end
    tests_run++;
    if (nn_cnt - nb !== 1 || wr_cnt - wb !== 2) begin
      failed++;
      $display("FAIL x_counts: got nn=%0d wr=%0d expected 1/2", nn_cnt - nb, wr_cnt - wb);
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (wr_sel_log[(wb + i) % 32] !== 1'b1 || wr_addr_log[(wb + i) % 32] !== 4'(i) ||
          wr_data_log[(wb + i) % 32] !== exp_d[i]) begin
        failed++;
        $display("FAIL x_write%0d: got sel=%b addr=%0d data=%h expected 1/%0d/%h", i,
                 wr_sel_log[(wb + i) % 32], wr_addr_log[(wb + i) % 32],
                 wr_data_log[(wb + i) % 32], i, exp_d[i]);
      end
    end
    idle(3);
    send_byte(8'h52);
    wait_tx(tb + 1, 50, got);
    tests_run++;
    if (!got || tx_log[(tb + 1) % 32] !== 8'h1C) begin
      failed++;
      $display("FAIL r_resend: got %h (seen=%0d) expected 1c", tx_log[(tb + 1) % 32], got);
    end
    idle(2);
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL r_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_bad_cmd;
    int wb = wr_cnt, tb = tx_cnt, nb = nn_cnt;
    bit got;
    send_byte(8'h41);
    wait_tx(tb, 50, got);
    tests_run++;
    if (!got || tx_log[tb % 32] !== 8'h3F) begin
      failed++;
      $display("FAIL e_reply: got %h (seen=%0d) expected 3f", tx_log[tb % 32], got);
    end
    tests_run++;
    if (wr_cnt != wb || nn_cnt != nb) begin
      failed++;
      $display("FAIL e_side_effects: got wr=%0d nn=%0d expected 0/0", wr_cnt - wb, nn_cnt - nb);
    end
    idle(3);
    send_byte(8'h58);
    send_byte(8'h01);
    send_byte(8'h02);
    wait_nn(nb, 20, got);
    idle(2);
    pulse_done(8'h25);
    wait_tx(tb + 1, 50, got);
    tests_run++;
    if (!got || tx_log[(tb + 1) % 32] !== 8'h25 || wr_cnt - wb !== 2) begin
      failed++;
      $display("FAIL e_recover: got tx=%h wr=%0d expected 25/2", tx_log[(tb + 1) % 32], wr_cnt - wb);
    end
    idle(3);
  endtask

  task automatic test_timeout;
    int wb = wr_cnt, tb = tx_cnt;
    bit got;
    send_byte(8'h57);
    idle(TMO - 20);
    send_byte(8'h10);
    idle(TMO - 10);
    tests_run++;
    if (tx_cnt != tb || busy !== 1'b1) begin
      failed++;
      $display("FAIL t_early: got tx=%0d busy=%b expected 0/1", tx_cnt - tb, busy);
    end
    wait_tx(tb, 100, got);
    tests_run++;
    if (!got || tx_log[tb % 32] !== 8'h3F) begin
      failed++;
      $display("FAIL t_reply: got %h (seen=%0d) expected 3f", tx_log[tb % 32], got);
    end
    idle(2);
    tests_run++;
    if (wr_cnt - wb !== 1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL t_state: got wr=%0d busy=%b expected 1/0", wr_cnt - wb, busy);
    end
  endtask

  task automatic test_tx_busy;
    int tb = tx_cnt;
    bit got;
    tx_busy = 1'b1;
    send_byte(8'h52);
    idle(500);
    tests_run++;
    if (tx_cnt != tb) begin
      failed++;
      $display("FAIL b_held: got %0d tx_start expected 0", tx_cnt - tb);
    end
    tx_busy = 1'b0;
    wait_tx(tb, 20, got);
    idle(20);
    tests_run++;
    if (!got || tx_cnt - tb !== 1 || tx_log[tb % 32] !== 8'h25) begin
      failed++;
      $display("FAIL b_release: got n=%0d data=%h expected 1/25", tx_cnt - tb, tx_log[tb % 32]);
    end
  endtask

  task automatic test_reset_mid;
    int nb = nn_cnt, tb;
    bit got;
    send_byte(8'h58);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_nn(nb, 20, got);
    idle(2);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wr_en, nn_start, tx_start, busy} !== 4'b0000 || tx_data !== 8'h00) begin
      failed++;
      $display("FAIL m_reset: got %b tx=%h expected 0000/00", {wr_en, nn_start, tx_start, busy}, tx_data);
    end
    idle(2);
    rst_n = 1'b1;
    tb = tx_cnt;
    pulse_done(8'h77);
    idle(20);
    tests_run++;
    if (tx_cnt != tb || busy !== 1'b0) begin
      failed++;
      $display("FAIL m_late_done: got tx=%0d busy=%b expected 0/0", tx_cnt - tb, busy);
    end
    send_byte(8'h52);
    wait_tx(tb, 50, got);
    tests_run++;
    if (!got || tx_log[tb % 32] !== 8'h00) begin
      failed++;
      $display("FAIL m_resend: got %h (seen=%0d) expected 00", tx_log[tb % 32], got);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_weights();
    test_eval();
    test_bad_cmd();
    test_timeout();
    test_tx_busy();
    test_reset_mid();
    tests_run++;
    if (viol != 0) begin
      failed++;
      $display("FAIL pulse_rules: got %0d overlap/busy violations expected 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
